// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared types and segment constants for the 7-segment scan controller
package seg7_pkg;

   // Scan sequencer states
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BLANK = 2'd1,
      SHOW  = 2'd2
   } state_t;

   // All segments off
   localparam logic [6:0] SEG_BLANK = 7'b0000000;

   // Hex digit to segments, bit6=a .. bit0=g, active high; entry 0 is the rightmost element
   localparam logic [15:0][6:0] HEX_SEG_TABLE = {
      7'b1000111,  // F
      7'b1001111,  // E
      7'b0111101,  // d
      7'b1001110,  // C
      7'b0011111,  // b
      7'b1110111,  // A
      7'b1111011,  // 9
      7'b1111111,  // 8
      7'b1110000,  // 7
      7'b1011111,  // 6
      7'b1011011,  // 5
      7'b0110011,  // 4
      7'b1111001,  // 3
      7'b1101101,  // 2
      7'b0110000,  // 1
      7'b1111110   // 0
   };

endpackage

// File: rtl/hex_seg_decode.sv
// rtl/hex_seg_decode.sv - combinational hex nibble to 7-segment decoder
module hex_seg_decode
   import seg7_pkg::*;
(
   input  logic [3:0] hex,
   output logic [6:0] seg
);

   assign seg = HEX_SEG_TABLE[hex];

endmodule

// File: rtl/seg7_scan_controller.sv
// rtl/seg7_scan_controller.sv - multiplexed 7-segment scanner; SEG7_LEADING_ZERO_BLANK_EN blanks leading zeros
module seg7_scan_controller
   import seg7_pkg::*;
#(
   parameter int NUM_DIGITS   = 4,
   parameter int PRESCALE     = 50000,
   parameter int BLANK_CYCLES = 16
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    load_valid,
   output logic                    load_ready,
   input  logic [4*NUM_DIGITS-1:0] load_data,
   input  logic                    display_en,
   output logic [6:0]              seg_out,
   output logic [NUM_DIGITS-1:0]   digit_sel,
   output logic                    frame_done
);

   localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int DW = 4 * NUM_DIGITS;

   localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
   localparam logic [CW-1:0] SHOW_LAST  = CW'(PRESCALE - BLANK_CYCLES - 1);
   localparam logic [IW-1:0] LAST_IDX   = IW'(NUM_DIGITS - 1);
   // With no blank gap every slot starts directly in SHOW
   localparam state_t        SLOT_START = (BLANK_CYCLES > 0) ? BLANK : SHOW;

   state_t          state, nxt_state;
   logic [IW-1:0]   idx, nxt_idx;
   logic [CW-1:0]   cnt, nxt_cnt;
   logic [DW-1:0]   disp_reg, nxt_disp;
   logic [DW-1:0]   shadow, nxt_shadow;
   logic            pending, nxt_pending;
   logic            nxt_frame;
   logic [3:0]      nib;
   logic [6:0]      dec_seg;
   logic [6:0]      nxt_seg;
   logic [NUM_DIGITS-1:0] nxt_sel;
   logic [IW-1:0]   top_idx;

   assign load_ready = !pending;

   // Next-state, slot sequencing and frame-aligned shadow-to-display transfer
   always_comb begin
      nxt_state   = state;
      nxt_idx     = idx;
      nxt_cnt     = cnt + CW'(1);
      nxt_disp    = disp_reg;
      nxt_shadow  = shadow;
      nxt_pending = pending;
      nxt_frame   = 1'b0;

      case (state)
         IDLE: begin
            nxt_cnt = '0;
            // Nothing is being shown, so a pending value can land immediately
            if (pending) begin
               nxt_disp    = shadow;
               nxt_pending = 1'b0;
            end
            if (display_en) begin
               nxt_idx   = '0;
               nxt_state = SLOT_START;
            end
         end
         BLANK: begin
            if (cnt == BLANK_LAST) begin
               nxt_cnt   = '0;
               nxt_state = SHOW;
            end
         end
         SHOW: begin
            if (cnt == SHOW_LAST) begin
               nxt_cnt   = '0;
               nxt_state = SLOT_START;
               if (idx == LAST_IDX) begin
                  nxt_idx   = '0;
                  nxt_frame = 1'b1;
                  if (pending) begin
                     nxt_disp    = shadow;
                     nxt_pending = 1'b0;
                  end
               end else begin
                  nxt_idx = idx + IW'(1);
               end
            end
         end
         default: begin
            nxt_state = IDLE;
            nxt_cnt   = '0;
            nxt_idx   = '0;
         end
      endcase

      // Disable wins over any slot or frame event this cycle
      if (!display_en) begin
         nxt_state = IDLE;
         nxt_idx   = '0;
         nxt_cnt   = '0;
         nxt_frame = 1'b0;
      end

      // A transfer only happens with pending clear, so it never collides with the loads above
      if (load_valid && !pending) begin
         nxt_shadow  = load_data;
         nxt_pending = 1'b1;
      end
   end

   // Select the nibble and digit enable for the slot being entered
   always_comb begin
      nib     = 4'h0;
      nxt_sel = '0;
      top_idx = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (nxt_idx == IW'(i)) begin
            nib        = nxt_disp[4*i +: 4];
            nxt_sel[i] = (nxt_state == SHOW);
         end
         if (nxt_disp[4*i +: 4] != 4'h0) begin
            top_idx = IW'(i);
         end
      end
   end

   hex_seg_decode u_dec (
      .hex (nib),
      .seg (dec_seg)
   );

   // Segment pattern for the slot being entered; blank outside SHOW
   always_comb begin
      nxt_seg = SEG_BLANK;
      if (nxt_state == SHOW) begin
`ifdef SEG7_LEADING_ZERO_BLANK_EN
         // Digit 0 is never above top_idx, so a zero value still shows one "0"
         nxt_seg = (nxt_idx > top_idx) ? SEG_BLANK : dec_seg;
`else
         nxt_seg = dec_seg;
`endif
      end
   end

   // State, datapath and registered outputs
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state      <= IDLE;
         idx        <= '0;
         cnt        <= '0;
         disp_reg   <= '0;
         shadow     <= '0;
         pending    <= 1'b0;
         seg_out    <= SEG_BLANK;
         digit_sel  <= '0;
         frame_done <= 1'b0;
      end else begin
         state      <= nxt_state;
         idx        <= nxt_idx;
         cnt        <= nxt_cnt;
         disp_reg   <= nxt_disp;
         shadow     <= nxt_shadow;
         pending    <= nxt_pending;
         seg_out    <= nxt_seg;
         digit_sel  <= nxt_sel;
         frame_done <= nxt_frame;
      end
   end

endmodule

// File: tb/tb_seg7_scan_controller.sv
// tb/tb_seg7_scan_controller.sv - self-checking bench for seg7_scan_controller
module tb_seg7_scan_controller;

   localparam int ND    = 4;
   localparam int PS    = 8;
   localparam int BC    = 2;
   localparam int FRAME = ND * PS;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        load_valid = 1'b0;
   logic        display_en = 1'b0;
   logic [15:0] load_data = 16'h0000;
   logic        load_ready;
   logic        frame_done;
   logic [6:0]  seg_out;
   logic [3:0]  digit_sel;

   always #5 clk = ~clk;

   seg7_scan_controller #(
      .NUM_DIGITS   (ND),
      .PRESCALE     (PS),
      .BLANK_CYCLES (BC)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .load_valid (load_valid),
      .load_ready (load_ready),
      .load_data  (load_data),
      .display_en (display_en),
      .seg_out    (seg_out),
      .digit_sel  (digit_sel),
      .frame_done (frame_done)
   );

   int n_cmp  = 0;
   int n_fail = 0;

   // Model: scanning is a running cycle count since enable; slot and phase follow by division
   bit          m_active  = 1'b0;
   int          m_k       = 0;
   logic [15:0] m_disp    = 16'h0000;
   logic [15:0] m_shadow  = 16'h0000;
   bit          m_pending = 1'b0;
   bit          m_fd      = 1'b0;

   function automatic logic [6:0] ref_seg(input logic [3:0] h);
      case (h)
         4'h0: return 7'b1111110;
         4'h1: return 7'b0110000;
         4'h2: return 7'b1101101;
         4'h3: return 7'b1111001;
         4'h4: return 7'b0110011;
         4'h5: return 7'b1011011;
         4'h6: return 7'b1011111;
         4'h7: return 7'b1110000;
         4'h8: return 7'b1111111;
         4'h9: return 7'b1111011;
         4'hA: return 7'b1110111;
         4'hB: return 7'b0011111;
         4'hC: return 7'b1001110;
         4'hD: return 7'b0111101;
         4'hE: return 7'b1001111;
         default: return 7'b1000111;
      endcase
   endfunction

   function automatic bit m_showing();
      return m_active && ((m_k % PS) >= BC);
   endfunction

   function automatic logic [3:0] exp_sel();
      if (!m_showing()) return 4'b0000;
      return 4'(1 << ((m_k % FRAME) / PS));
   endfunction

   function automatic logic [6:0] exp_seg();
      int d;
      int top;
      if (!m_showing()) return 7'b0000000;
      d = (m_k % FRAME) / PS;
      top = 0;
      for (int i = 0; i < ND; i++) if (m_disp[4*i +: 4] != 4'h0) top = i;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
      if (d > top) return 7'b0000000;
`endif
      return ref_seg(m_disp[4*d +: 4]);
   endfunction

   task automatic model_edge();
      bit xfer;
      xfer = load_valid && !m_pending;
      m_fd = 1'b0;
      if (!reset_n) begin
         m_active = 1'b0; m_k = 0; m_disp = '0; m_shadow = '0; m_pending = 1'b0;
         return;
      end
      if (!display_en) begin
         if (!m_active && m_pending) begin m_disp = m_shadow; m_pending = 1'b0; end
         m_active = 1'b0;
         m_k = 0;
      end else if (!m_active) begin
         if (m_pending) begin m_disp = m_shadow; m_pending = 1'b0; end
         m_active = 1'b1;
         m_k = 0;
      end else begin
         m_k = m_k + 1;
         if (m_k % FRAME == 0) begin
            m_fd = 1'b1;
            if (m_pending) begin m_disp = m_shadow; m_pending = 1'b0; end
         end
      end
      if (xfer) begin m_shadow = load_data; m_pending = 1'b1; end
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // One clock: advance the model across the edge, then compare every output
   task automatic tick();
      model_edge();
      @(posedge clk);
      #1;
      check("seg_out",    32'(seg_out),    32'(exp_seg()));
      check("digit_sel",  32'(digit_sel),  32'(exp_sel()));
      check("frame_done", 32'(frame_done), 32'(m_fd));
      check("load_ready", 32'(load_ready), 32'(!m_pending));
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic run_to_phase(input int ph);
      bit hit;
      hit = 1'b0;
      for (int g = 0; g < 200; g++) begin
         if (m_active && (m_k % FRAME) == ph) begin hit = 1'b1; break; end
         tick();
      end
      check("phase_reach", 32'(hit), 32'd1);
   endtask

   task automatic load_one(input logic [15:0] v);
      load_valid = 1'b1;
      load_data  = v;
      tick();
      load_valid = 1'b0;
   endtask

   initial begin
      int t1, t2, n;
      bit done;

      // Reset state
      ticks(3);
      check("rst_seg", 32'(seg_out), 32'h0);
      check("rst_sel", 32'(digit_sel), 32'h0);
      check("rst_ready", 32'(load_ready), 32'd1);
      reset_n = 1'b1;
      ticks(2);

      // Enable with no load: zeros on every digit, 32-cycle frames
      display_en = 1'b1;
      tick();
      check("first_blank_sel", 32'(digit_sel), 32'h0);
      ticks(2);
      check("d0_sel", 32'(digit_sel), 32'b0001);
      check("d0_seg", 32'(seg_out), 32'b1111110);
      t1 = -1; t2 = -1; n = 2;
      for (int g = 0; g < 80 && t2 < 0; g++) begin
         tick(); n++;
         if (frame_done) begin
            if (t1 < 0) t1 = n; else t2 = n;
         end
      end
      check("first_fd_cycle", 32'(t1), 32'd32);
      check("fd_period", 32'(t2 - t1), 32'd32);

      // Load while IDLE, then enable
      display_en = 1'b0;
      tick();
      load_one(16'h1A3F);
      tick();
      display_en = 1'b1;
      tick();
      run_to_phase(2);
      check("1A3F_d0", 32'(seg_out), 32'b1000111);
      run_to_phase(10);
      check("1A3F_d1", 32'(seg_out), 32'b1111001);
      run_to_phase(18);
      check("1A3F_d2", 32'(seg_out), 32'b1110111);
      run_to_phase(26);
      check("1A3F_d3", 32'(seg_out), 32'b0110000);
      check("1A3F_d3_sel", 32'(digit_sel), 32'b1000);

      // Back-to-back mid-frame loads: second one stalls until the wrap frees the shadow
      load_one(16'h0000);
      load_valid = 1'b1;
      load_data  = 16'h2222;
      check("stall_ready", 32'(load_ready), 32'd0);
      done = 1'b0;
      for (int g = 0; g < 100; g++) begin
         done = load_ready;
         tick();
         if (done) break;
      end
      load_valid = 1'b0;
      check("xfer_done", 32'(done), 32'd1);
      check("xfer_phase", 32'(m_k % FRAME), 32'd1);
      run_to_phase(2);
      check("zero_d0", 32'(seg_out), 32'b1111110);
      tick();
      run_to_phase(2);
      check("2222_d0", 32'(seg_out), 32'b1101101);

      // Transfer on the exact wrap edge applies one frame later
      run_to_phase(31);
      load_one(16'h5555);
      check("wrap_fd", 32'(frame_done), 32'd1);
      run_to_phase(2);
      check("wrap_old_d0", 32'(seg_out), 32'b1101101);
      tick();
      run_to_phase(2);
      check("wrap_new_d0", 32'(seg_out), 32'b1011011);

      // Drop display_en mid-SHOW of digit 2
      run_to_phase(20);
      check("d2_sel", 32'(digit_sel), 32'b0100);
      display_en = 1'b0;
      tick();
      check("dis_sel", 32'(digit_sel), 32'h0);
      check("dis_seg", 32'(seg_out), 32'h0);
      ticks(3);
      display_en = 1'b1;
      tick();
      check("reen_blank", 32'(digit_sel), 32'h0);
      ticks(2);
      check("reen_sel", 32'(digit_sel), 32'b0001);

      // Reset mid-frame with a pending value
      load_one(16'h1234);
      check("pend_ready", 32'(load_ready), 32'd0);
      reset_n = 1'b0;
      tick();
      check("midrst_ready", 32'(load_ready), 32'd1);
      check("midrst_sel", 32'(digit_sel), 32'h0);
      tick();
      reset_n = 1'b1;
      tick();
      run_to_phase(2);
      check("postrst_d0", 32'(seg_out), 32'b1111110);
      run_to_phase(10);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
      check("postrst_d1", 32'(seg_out), 32'b0000000);
`else
      check("postrst_d1", 32'(seg_out), 32'b1111110);
`endif
      check("postrst_d1_sel", 32'(digit_sel), 32'b0010);

      // Value 0050: leading-zero behaviour
      display_en = 1'b0;
      tick();
      load_one(16'h0050);
      tick();
      display_en = 1'b1;
      tick();
      run_to_phase(2);
      check("0050_d0", 32'(seg_out), 32'b1111110);
      run_to_phase(10);
      check("0050_d1", 32'(seg_out), 32'b1011011);
      run_to_phase(18);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
      check("0050_d2", 32'(seg_out), 32'b0000000);
`else
      check("0050_d2", 32'(seg_out), 32'b1111110);
`endif
      check("0050_d2_sel", 32'(digit_sel), 32'b0100);
      run_to_phase(26);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
      check("0050_d3", 32'(seg_out), 32'b0000000);
`else
      check("0050_d3", 32'(seg_out), 32'b1111110);
`endif
      ticks(4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/seg7_scan_controller.md
Name: seg7_scan_controller

Overview:
- Time-multiplexes a NUM_DIGITS-wide hex value onto one shared 7-segment bus with one-hot digit selects.
- Sequences digit slots with a prescaler and inserts an anti-ghosting blank gap between slots.
- Accepts new display values through a valid/ready handshake and applies them only at frame boundaries, so a frame never shows mixed values.
- Sits between the value-producing logic and the board's segment/anode pins.

Parameters:
- NUM_DIGITS, 4: digit positions; range 1..8.
- PRESCALE, 50000: clk cycles per digit slot, blank gap included; must be > BLANK_CYCLES.
- BLANK_CYCLES, 16: cycles per slot with all outputs low; 0 removes the BLANK state.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset_n  input  1  synchronous reset, active-low.
- load_valid  input  1  load_data is valid.
- load_ready  output  1  shadow register free; a transfer occurs when load_valid and load_ready are both high.
- load_data  input  4*NUM_DIGITS  nibble i drives digit i; digit 0 is the least significant.
- display_en  input  1  scanning enabled.
- seg_out  output  7  active-high segments, bit6=a through bit0=g.
- digit_sel  output  NUM_DIGITS  one-hot active-high digit enable.
- frame_done  output  1  one-cycle pulse at each frame wrap.

Behaviour:
- Reset: a synchronous, active-low reset_n returns the block to its reset state.
  - seg_out=0, digit_sel=0, frame_done=0, load_ready=1.
  - Internal: state=IDLE, idx=0, slot counter=0, disp_reg=0, shadow=0, pending=0.
  - Asserting reset mid-slot or mid-handshake discards everything, including any pending value.
- Output timing: seg_out and digit_sel are registered and computed from next-state, so they change on the same edge the FSM enters a state.
- FSM states: IDLE, BLANK, SHOW.
  - IDLE: outputs 0. When display_en=1, go to BLANK with idx=0, or to SHOW if BLANK_CYCLES=0.
  - BLANK: digit_sel=0, seg_out=0 for exactly BLANK_CYCLES cycles, then SHOW.
  - SHOW: digit_sel=1<<idx and seg_out=decode(disp_reg[4*idx+:4]) for exactly PRESCALE-BLANK_CYCLES cycles. At slot end, idx increments and the FSM returns to BLANK (or stays in SHOW if BLANK_CYCLES=0).
- Wrap: when idx=NUM_DIGITS-1 ends its slot:
  - idx returns to 0 and frame_done pulses for one cycle.
  - If pending=1, disp_reg is loaded from shadow and pending clears on that edge.
- Disable: display_en=0 in any state takes the FSM to IDLE on the next edge and resets idx and the counter; outputs are 0 on that edge.
- Handshake:
  - load_ready = !pending.
  - On a transfer, shadow is loaded from load_data and pending is set to 1.
  - While in IDLE, a pending value moves to disp_reg on the following cycle (no frame to tear).
- Simultaneous events:
  - A transfer on the same edge as a wrap is not applied at that wrap; pending was sampled as 0 there, so it applies at the next wrap.
  - load_valid held while load_ready=0 is ignored; no data is lost, and the producer holds until ready.
- Decode table, hex digit to seg_out:
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001
  - 4=0110011, 5=1011011, 6=1011111, 7=1110000
  - 8=1111111, 9=1111011, A=1110111, b=0011111
  - C=1001110, d=0111101, E=1001111, F=1000111
- Counters: slot counter width is clog2(PRESCALE). It wraps to 0 at every state change, and there is no overflow path.

Optional Feature:
- Macro: SEG7_LEADING_ZERO_BLANK_EN.
- Defined: in SHOW, for any idx above the highest nonzero nibble of disp_reg, seg_out=0 while digit_sel stays asserted (constant brightness timing). Digit 0 is always decoded, so value 0 shows a single "0".
- Undefined: every digit is decoded, including leading zeros.

Decomposition:
- Package seg7_pkg holds:
  - the state enum (IDLE/BLANK/SHOW);
  - SEG_BLANK=7'b0000000;
  - the 16-entry hex segment constant table.
- Sub-module hex_seg_decode: combinational 4-bit to 7-bit decode, shared with other display logic. The controller instantiates one copy, muxed by idx.

Test Plan (NUM_DIGITS=4, PRESCALE=8, BLANK_CYCLES=2):
- Reset, then display_en=1 with no load -> per slot: 2 cycles of digit_sel=0000, then 6 cycles of digit_sel=0001/0010/0100/1000 in order with seg_out=1111110; frame_done pulses every 32 cycles.
- Load 16'h1A3F while IDLE, then enable -> slot segments 1000111, 1111001, 1110111, 0110000 for digits 0..3.
- Mid-frame load 16'h0000 then 16'h2222 back-to-back -> second load_valid sees load_ready=0 and stalls; display changes to all-zeros only on the cycle after the frame_done edge; the 2222 transfer completes that same cycle and appears one frame later.
- Transfer on the exact wrap edge -> value is not displayed until the following wrap.
- display_en dropped mid-SHOW of digit 2 -> next edge: digit_sel=0, seg_out=0; re-enable restarts at digit 0 with BLANK.
- reset_n low mid-frame with pending=1 -> all outputs 0 and load_ready=1; after release and enable, digits show 1111110. With SEG7_LEADING_ZERO_BLANK_EN, value 16'h0050 -> digits 3 and 2 show 0000000, digit 1 shows 1011011, digit 0 shows 1111110.
